seq_signed_divider: RTL

- Multi-cycle signed/unsigned integer divider for the processor execute stage.
- Sits directly downstream of the operand two's-complement negation path:
  - converts signed operands to magnitudes;
  - runs a restoring shift-subtract loop, one quotient bit per cycle;
  - re-applies signs to the results.
- Uses a valid/ready handshake on both sides so the pipeline can stall around it.

---
 rtl/seq_signed_divider_if.sv | 29 ++
 rtl/seq_signed_divider.sv | 128 ++++++++++++
 2 files changed

// File: rtl/seq_signed_divider_if.sv
// seq_signed_divider_if: operand/result handshake bundle for seq_signed_divider.
//   in_valid/in_ready   operand handshake, master -> slave
//   dividend/divisor    WIDTH+1-bit operands
//   is_signed           1 = two's-complement operands
//   out_valid/out_ready result handshake, slave -> master
//   quotient/remainder  WIDTH+1-bit results
//   div_by_zero         divisor was zero for this result
interface seq_signed_divider_if #(
    parameter int WIDTH = 63
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   dividend;
    logic [WIDTH:0]   divisor;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   quotient;
    logic [WIDTH:0]   remainder;
    logic             div_by_zero;
    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: multi-cycle restoring signed/unsigned divider, one quotient bit per cycle.
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    seq_signed_divider_if.slave: operand handshake in, result handshake out
module seq_signed_divider #(
    parameter int WIDTH = 63
) (
    input logic                 clk,
    input logic                 rst_n,
    seq_signed_divider_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PREP   = 3'd1;
    localparam logic [2:0] DIVIDE = 3'd2;
    localparam logic [2:0] FIXUP  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam int         CW     = $clog2(WIDTH + 1);

    logic [2:0]     state_q, state_d;
    logic [WIDTH:0] dvd_q, dvd_d;
    logic [WIDTH:0] dsr_q, dsr_d;
    logic [WIDTH:0] rem_q, rem_d;
    logic [WIDTH:0] orig_q, orig_d;
    logic [WIDTH:0] quo_q, quo_d;
    logic [WIDTH:0] rmd_q, rmd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sgn_q, sgn_d;
    logic           negq_q, negq_d;
    logic           negr_q, negr_d;
    logic           zero_q, zero_d;
    logic           dbz_q, dbz_d;
    logic [WIDTH+1:0] shift_w;
    logic [WIDTH+1:0] trial_w;

    // Partial remainder stays below the divisor, so the top bit of the
    // WIDTH+2-bit difference is a reliable borrow/sign flag.
    assign shift_w = {rem_q, dvd_q[WIDTH]};
    assign trial_w = shift_w - {1'b0, dsr_q};

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        orig_d  = orig_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                dvd_d   = bus.dividend;
                orig_d  = bus.dividend;
                dsr_d   = bus.divisor;
                sgn_d   = bus.is_signed;
                state_d = PREP;
            end
            PREP: begin
                dvd_d   = (sgn_q && dvd_q[WIDTH]) ? -dvd_q : dvd_q;
                dsr_d   = (sgn_q && dsr_q[WIDTH]) ? -dsr_q : dsr_q;
                negq_d  = sgn_q && (dvd_q[WIDTH] ^ dsr_q[WIDTH]);
                negr_d  = sgn_q && dvd_q[WIDTH];
                zero_d  = dsr_q == '0;
                rem_d   = '0;
                cnt_d   = '0;
                // A zero divisor skips the loop but still lands its result
                // through FIXUP, giving it a fixed two-cycle latency.
                state_d = (dsr_q == '0) ? FIXUP : DIVIDE;
            end
            DIVIDE: begin
                dvd_d   = {dvd_q[WIDTH-1:0], ~trial_w[WIDTH+1]};
                rem_d   = trial_w[WIDTH+1] ? shift_w[WIDTH:0] : trial_w[WIDTH:0];
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WIDTH)) ? FIXUP : DIVIDE;
            end
            FIXUP: begin
                quo_d   = zero_q ? '1 : (negq_q ? -dvd_q : dvd_q);
                rmd_d   = zero_q ? orig_q : (negr_q ? -rem_q : rem_q);
                dbz_d   = zero_q;
                state_d = DONE;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            orig_q  <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            orig_q  <= orig_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.in_ready    = state_q == IDLE;
    assign bus.out_valid   = state_q == DONE;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;
endmodule
